// File: rtl/cxu_responder.sv
// CXU responder: answers cx_req_* with a small ALU, an iterative shift-add multiplier
// and per-context 32-bit accumulators. One request in flight; outputs are registered.
module cxu_responder #(
    parameter logic [1:0] CXU_ID     = 2'd0,
    parameter int         NUM_STATES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cx_rst,
    input  logic        cx_req_valid,
    input  logic [1:0]  cx_cxu_id,
    input  logic [1:0]  cx_state_id,
    input  logic [24:0] cx_func,
    input  logic [31:0] cx_req_data0,
    input  logic [31:0] cx_req_data1,
    output logic        cx_resp_valid,
    output logic        cx_resp_state,
    output logic [3:0]  cx_resp_status,
    output logic [31:0] cx_resp_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, MULT, RESP} state_e;

    localparam logic [2:0] NS = 3'(NUM_STATES);

    state_e      state_q, state_d;
    logic [2:0]  func_q, func_d;
    logic [1:0]  sid_q, sid_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q [4];
    logic [31:0] acc_d [4];
    logic [3:0]  dirty_q, dirty_d;
    logic        rv_q, rv_d;
    logic        rs_q, rs_d;
    logic [3:0]  st_q, st_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] prod_nxt;
    logic [31:0] acc_new;
    logic        uses_state;
    logic        unused_func;

    assign unused_func = ^cx_func[24:3];

    function automatic logic [31:0] popcnt(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {31'd0, v[i]};
        return c;
    endfunction

    assign prod_nxt   = prod_q + (b_q[0] ? a_q : 32'd0);
    assign acc_new    = acc_q[sid_q] + prod_nxt;
    assign uses_state = (cx_func[2:0] == 3'd3) || (cx_func[2:0] == 3'd4) || (cx_func[2:0] == 3'd5);

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        sid_d   = sid_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dirty_d = dirty_q;
        rv_d    = 1'b0;
        rs_d    = 1'b0;
        st_d    = 4'd0;
        rd_d    = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (cx_req_valid) begin
                    func_d = cx_func[2:0];
                    sid_d  = cx_state_id;
                    a_d    = cx_req_data0;
                    b_d    = cx_req_data1;
                    prod_d = 32'd0;
                    cnt_d  = 5'd0;
                    // Error responses skip execution and never touch accumulator state.
                    if (cx_cxu_id != CXU_ID) begin
                        state_d = RESP; rv_d = 1'b1; st_d = 4'd2;
                    end else if (uses_state && ({1'b0, cx_state_id} >= NS)) begin
                        state_d = RESP; rv_d = 1'b1; st_d = 4'd3;
                    end else if (cx_func[2:0] == 3'd7) begin
                        state_d = RESP; rv_d = 1'b1; st_d = 4'd1;
                    end else if (cx_func[2:0] == 3'd2 || cx_func[2:0] == 3'd3) begin
                        state_d = MULT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = RESP;
                rv_d    = 1'b1;
                case (func_q)
                    3'd0: rd_d = a_q + b_q;
                    3'd1: rd_d = a_q - b_q;
                    3'd4: begin
                        rd_d = acc_q[sid_q];
                        rs_d = dirty_q[sid_q];
                    end
                    3'd5: begin
                        rd_d           = acc_q[sid_q];
                        rs_d           = 1'b1;
                        acc_d[sid_q]   = a_q;
                        dirty_d[sid_q] = 1'b1;
                    end
                    3'd6:    rd_d = popcnt(a_q);
                    default: rd_d = 32'd0;
                endcase
            end
            MULT: begin
                // One multiplier bit per cycle, LSB first; multiplicand shifts left.
                prod_d = prod_nxt;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = RESP;
                    rv_d    = 1'b1;
                    if (func_q == 3'd3) begin
                        rd_d           = acc_new;
                        rs_d           = 1'b1;
                        acc_d[sid_q]   = acc_new;
                        dirty_d[sid_q] = 1'b1;
                    end else begin
                        rd_d = prod_nxt;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cx_rst) begin
            state_d = IDLE;
            dirty_d = 4'd0;
            for (int i = 0; i < 4; i++) acc_d[i] = 32'd0;
            rv_d = 1'b0;
            rs_d = 1'b0;
            st_d = 4'd0;
            rd_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            func_q  <= 3'd0;
            sid_q   <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            prod_q  <= 32'd0;
            cnt_q   <= 5'd0;
            for (int i = 0; i < 4; i++) acc_q[i] <= 32'd0;
            dirty_q <= 4'd0;
            rv_q    <= 1'b0;
            rs_q    <= 1'b0;
            st_q    <= 4'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            sid_q   <= sid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dirty_q <= dirty_d;
            rv_q    <= rv_d;
            rs_q    <= rs_d;
            st_q    <= st_d;
            rd_q    <= rd_d;
        end
    end

    assign cx_resp_valid  = rv_q;
    assign cx_resp_state  = rs_q;
    assign cx_resp_status = st_q;
    assign cx_resp_data   = rd_q;
    // The acceptance cycle itself counts as busy, before the FSM has left IDLE.
    assign busy = ~reset & ((state_q != IDLE) | (cx_req_valid & ~cx_rst));

endmodule

// File: tb/tb_cxu_responder.sv
// Scoreboard bench for cxu_responder: directed requests push expected responses,
// an independent monitor pops and compares on every cx_resp_valid.
module tb_cxu_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cx_rst = 1'b0;
    logic        cx_req_valid = 1'b0;
    logic [1:0]  cx_cxu_id = 2'd0;
    logic [1:0]  cx_state_id = 2'd0;
    logic [24:0] cx_func = 25'd0;
    logic [31:0] cx_req_data0 = 32'd0;
    logic [31:0] cx_req_data1 = 32'd0;
    logic        cx_resp_valid;
    logic        cx_resp_state;
    logic [3:0]  cx_resp_status;
    logic [31:0] cx_resp_data;
    logic        busy;

    cxu_responder #(.CXU_ID(2'd0), .NUM_STATES(3)) dut (
        .clk(clk), .reset(reset), .cx_rst(cx_rst), .cx_req_valid(cx_req_valid),
        .cx_cxu_id(cx_cxu_id), .cx_state_id(cx_state_id), .cx_func(cx_func),
        .cx_req_data0(cx_req_data0), .cx_req_data1(cx_req_data1),
        .cx_resp_valid(cx_resp_valid), .cx_resp_state(cx_resp_state),
        .cx_resp_status(cx_resp_status), .cx_resp_data(cx_resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        st;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rcv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && cx_resp_valid) begin
            n_rcv++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp cyc=%0d data=%h status=%0d", cyc, cx_resp_data, cx_resp_status);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cx_resp_data !== e.d || cx_resp_status !== e.s || cx_resp_state !== e.st || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL resp got data=%h status=%0d state=%0d cyc=%0d, want data=%h status=%0d state=%0d cyc=%0d",
                             cx_resp_data, cx_resp_status, cx_resp_state, cyc, e.d, e.s, e.st, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] id, input logic [1:0] sid, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        cx_cxu_id    = id;
        cx_state_id  = sid;
        cx_func      = {22'h2AAAAA, f};
        cx_req_data0 = a;
        cx_req_data1 = b;
        cx_req_valid = 1'b1;
    endtask

    task automatic issue(input string nm, input logic [1:0] id, input logic [1:0] sid, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic [3:0] es, input logic est,
                         input int lat, input bit chk_busy);
        int t0;
        int nb;
        exp_t e;
        @(posedge clk); #1;
        drive(id, sid, f, a, b);
        t0 = cyc;
        e.d = ed; e.s = es; e.st = est; e.cyc = t0 + lat;
        sb.push_back(e);
        nb = 0;
        @(negedge clk);
        if (busy) nb++;
        @(posedge clk); #1;
        cx_req_valid = 1'b0;
        cx_req_data0 = 32'hDEAD_BEEF;
        cx_req_data1 = 32'h1234_5678;
        while (cyc <= t0 + lat + 1) begin
            @(negedge clk);
            if (busy) nb++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s missing_resp by cyc=%0d", nm, t0 + lat);
            sb.delete();
        end
        if (chk_busy) begin
            n_vec++;
            if (nb != lat + 1) begin
                n_err++;
                $display("FAIL %s busy_cycles got=%0d want=%0d", nm, nb, lat + 1);
            end
        end
    endtask

    initial begin
        int t0;
        int r0;
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (cx_resp_valid !== 1'b0 || cx_resp_data !== 32'd0 || cx_resp_status !== 4'd0 ||
            cx_resp_state !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b d=%h s=%0d st=%b busy=%b want all 0",
                     cx_resp_valid, cx_resp_data, cx_resp_status, cx_resp_state, busy);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);

        issue("add_wrap", 2'd0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd0, 1'b0, 2, 1'b0);
        issue("mul",      2'd0, 2'd0, 3'd2, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 4'd0, 1'b0, 33, 1'b1);
        issue("wrst_s1",  2'd0, 2'd1, 3'd5, 32'd10, 32'd0, 32'd0, 4'd0, 1'b1, 2, 1'b0);
        issue("mac_s1",   2'd0, 2'd1, 3'd3, 32'd3, 32'd4, 32'd22, 4'd0, 1'b1, 33, 1'b0);
        issue("rdst_s1",  2'd0, 2'd1, 3'd4, 32'd0, 32'd0, 32'd22, 4'd0, 1'b1, 2, 1'b0);
        issue("rdst_s2",  2'd0, 2'd2, 3'd4, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 2, 1'b0);
        issue("bad_cxu",  2'd1, 2'd0, 3'd0, 32'd5, 32'd6, 32'd0, 4'd2, 1'b0, 1, 1'b0);
        issue("bad_func", 2'd0, 2'd0, 3'd7, 32'd5, 32'd6, 32'd0, 4'd1, 1'b0, 1, 1'b0);
        issue("bad_sid",  2'd0, 2'd3, 3'd3, 32'd3, 32'd4, 32'd0, 4'd3, 1'b0, 1, 1'b0);
        issue("rdst_s1b", 2'd0, 2'd1, 3'd4, 32'd0, 32'd0, 32'd22, 4'd0, 1'b1, 2, 1'b0);
        issue("sub",      2'd0, 2'd0, 3'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'd0, 1'b0, 2, 1'b0);
        issue("popcnt",   2'd0, 2'd0, 3'd6, 32'hF0F0_0001, 32'd0, 32'd9, 4'd0, 1'b0, 2, 1'b0);

        // Soft reset in the middle of a MAC: no response, accumulators cleared.
        @(posedge clk); #1;
        drive(2'd0, 2'd1, 3'd3, 32'd3, 32'd4);
        t0 = cyc;
        r0 = n_rcv;
        @(posedge clk); #1;
        cx_req_valid = 1'b0;
        while (cyc < t0 + 10) @(posedge clk);
        #1 cx_rst = 1'b1;
        @(posedge clk); #1 cx_rst = 1'b0;
        while (cyc <= t0 + 40) @(negedge clk);
        n_vec++;
        if (n_rcv != r0) begin
            n_err++;
            $display("FAIL cx_rst_abort responses got=%0d want=0", n_rcv - r0);
        end
        issue("rdst_clr", 2'd0, 2'd1, 3'd4, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 2, 1'b0);

        // Async reset in the middle of a MUL.
        @(posedge clk); #1;
        drive(2'd0, 2'd0, 3'd2, 32'd7, 32'd9);
        t0 = cyc;
        @(posedge clk); #1;
        cx_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_vec++;
        if (cx_resp_valid !== 1'b0 || cx_resp_data !== 32'd0 || cx_resp_status !== 4'd0 ||
            cx_resp_state !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_outputs got v=%b d=%h s=%0d st=%b busy=%b want all 0",
                     cx_resp_valid, cx_resp_data, cx_resp_status, cx_resp_state, busy);
        end
        r0 = n_rcv;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        n_vec++;
        if (n_rcv != r0) begin
            n_err++;
            $display("FAIL async_reset_abort responses got=%0d want=0", n_rcv - r0);
        end

        // Strobe held across RESP: re-accepted in the following IDLE cycle.
        @(posedge clk); #1;
        drive(2'd0, 2'd0, 3'd0, 32'd2, 32'd3);
        t0 = cyc;
        e.d = 32'd5; e.s = 4'd0; e.st = 1'b0; e.cyc = t0 + 2;
        sb.push_back(e);
        e.cyc = t0 + 5;
        sb.push_back(e);
        while (cyc < t0 + 4) @(posedge clk);
        #1 cx_req_valid = 1'b0;
        while (cyc <= t0 + 8) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL back_to_back missing=%0d want=0", sb.size());
            sb.delete();
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
